// File: rtl/reg_file_mp_pkg.sv
// Shared definitions for the multi-port register file: sweep FSM states.
package reg_file_mp_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } sweep_st_e;

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: write, reserve, per-port read and clear-sweep signals.
interface reg_file_mp_if #(
   parameter int W  = 8,
   parameter int A  = 4,
   parameter int NR = 2
);
   logic                  WrEn;
   logic [A-1:0]          WrAddr;
   logic [W-1:0]          WrData;
   logic [NR-1:0]         RdEn;
   logic [NR-1:0][A-1:0]  RdAddr;
   logic [NR-1:0][W-1:0]  RdData;
   logic [NR-1:0]         RdPending;
   logic                  ResvEn;
   logic [A-1:0]          ResvAddr;
   logic                  ClearReq;
   logic                  Busy;
   logic                  ClearDone;

   modport master (
      output WrEn, WrAddr, WrData, RdEn, RdAddr, ResvEn, ResvAddr, ClearReq,
      input  RdData, RdPending, Busy, ClearDone
   );

   modport slave (
      input  WrEn, WrAddr, WrData, RdEn, RdAddr, ResvEn, ResvAddr, ClearReq,
      output RdData, RdPending, Busy, ClearDone
   );
endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// reg_scoreboard: one pending bit per register with set/clear/clear-all and NR lookups.
module reg_scoreboard #(
   parameter int A  = 4,
   parameter int NR = 2
) (
   input  logic                 clk_i,
   input  logic                 clr_all_i,
   input  logic                 set_en_i,
   input  logic [A-1:0]         set_addr_i,
   input  logic                 clr_en_i,
   input  logic [A-1:0]         clr_addr_i,
   input  logic [NR-1:0][A-1:0] lk_addr_i,
   output logic [NR-1:0]        lk_pend_o
);
   localparam int DEPTH = 2**A;

   logic [DEPTH-1:0] pend_q;

   // Set is applied after clear so a same-address reserve wins over a write.
   always_ff @(posedge clk_i) begin
      if (clr_all_i) begin
         pend_q <= '0;
      end else begin
         if (clr_en_i) pend_q[clr_addr_i] <= 1'b0;
         if (set_en_i) pend_q[set_addr_i] <= 1'b1;
      end
   end

   always_comb begin
      lk_pend_o = '0;
      for (int p = 0; p < NR; p++) lk_pend_o[p] = pend_q[lk_addr_i[p]];
   end
endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with pending scoreboard and clear sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching reads.
module reg_file_mp
   import reg_file_mp_pkg::*;
#(
   parameter int W       = 8,
   parameter int A       = 4,
   parameter int NR      = 2,
   parameter int R0_ZERO = 0
) (
   input  logic         Clk,
   input  logic         Reset,
   reg_file_mp_if.slave bus
);
   localparam int DEPTH = 2**A;
   localparam bit R0Z   = (R0_ZERO != 0);

   logic [W-1:0]          mem_q [DEPTH];
   sweep_st_e             state_q, state_d;
   logic [A-1:0]          idx_q, idx_d;
   logic                  done_q, done_d;
   logic [NR-1:0][W-1:0]  rd_data_q, rd_data_d;
   logic [NR-1:0]         rd_pend_q, rd_pend_d;
   logic [NR-1:0]         sb_pend;
   logic                  busy, wr_ok, resv_ok;

   assign busy    = (state_q == SWEEP);
   assign wr_ok   = bus.WrEn   && !busy && !(R0Z && bus.WrAddr   == '0);
   assign resv_ok = bus.ResvEn && !busy && !(R0Z && bus.ResvAddr == '0);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: if (bus.ClearReq) begin
            state_d = SWEEP;
            idx_d   = '0;
         end
         SWEEP: begin
            idx_d = idx_q + 1'b1;
            if (idx_q == A'(DEPTH-1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (busy) begin
         mem_q[idx_q] <= '0;
      end else if (wr_ok) begin
         mem_q[bus.WrAddr] <= bus.WrData;
      end
   end

   // The sweep reuses the single clear port; writes cannot occur while busy.
   reg_scoreboard #(.A(A), .NR(NR)) u_sb (
      .clk_i      (Clk),
      .clr_all_i  (Reset),
      .set_en_i   (resv_ok),
      .set_addr_i (bus.ResvAddr),
      .clr_en_i   (wr_ok || busy),
      .clr_addr_i (busy ? idx_q : bus.WrAddr),
      .lk_addr_i  (bus.RdAddr),
      .lk_pend_o  (sb_pend)
   );

   always_comb begin
      rd_data_d = '0;
      rd_pend_d = '0;
      for (int p = 0; p < NR; p++) begin
         rd_data_d[p] = mem_q[bus.RdAddr[p]];
         rd_pend_d[p] = sb_pend[p];
`ifdef REGFILE_BYPASS_EN
         if (wr_ok && bus.RdAddr[p] == bus.WrAddr) begin
            rd_data_d[p] = bus.WrData;
            rd_pend_d[p] = resv_ok && (bus.ResvAddr == bus.WrAddr);
         end
`endif
         if (R0Z && bus.RdAddr[p] == '0) begin
            rd_data_d[p] = '0;
            rd_pend_d[p] = 1'b0;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         rd_data_q <= '0;
         rd_pend_q <= '0;
      end else begin
         for (int p = 0; p < NR; p++) begin
            if (bus.RdEn[p]) begin
               rd_data_q[p] <= rd_data_d[p];
               rd_pend_q[p] <= rd_pend_d[p];
            end
         end
      end
   end

   assign bus.RdData    = rd_data_q;
   assign bus.RdPending = rd_pend_q;
   assign bus.Busy      = busy;
   assign bus.ClearDone = done_q;
endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter W, default 8: data width in bits.
REQ-002 Parameter A, default 4: address width; depth is 2**A registers.
REQ-003 Parameter NR, default 2: number of read ports, 1..4.
REQ-004 Parameter R0_ZERO, default 0: 1 makes register 0 read-as-zero and ignores writes to it.
REQ-005 Clk  in  1  sole clock; all state updates on rising edge.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 WrEn / WrAddr / WrData  in  1 / A / W  write strobe, address and data.
REQ-008 RdEn / RdAddr  in  NR / NR*A  per-port read strobe and packed read addresses.
REQ-009 RdData / RdPending  out  NR*W / NR  packed registered read data and pending flag per port.
REQ-010 ResvEn / ResvAddr  in  1 / A  marks a register as awaiting a producer (scoreboard set).
REQ-011 ClearReq  in  1  starts a sweep that zeroes every register.
REQ-012 Busy / ClearDone  out  1 / 1  sweep in progress; one-cycle pulse when sweep ends.

Function
REQ-013 Reads SHALL have 1-cycle latency: RdData[p] and RdPending[p] update the cycle after RdEn[p]=1 and hold their value while RdEn[p]=0.
REQ-014 A write SHALL update the addressed register at the edge on which WrEn=1.
REQ-015 With R0_ZERO=1, reads of address 0 SHALL return 0 with RdPending=0; writes and reserves to address 0 SHALL be ignored.
REQ-016 Pending[ResvAddr] SHALL set when ResvEn=1; Pending[WrAddr] SHALL clear when WrEn=1.
REQ-017 ResvEn and WrEn to the same address in one cycle: data written, Pending left set (reserve wins).
REQ-018 The sweep FSM SHALL have states IDLE and SWEEP; ClearReq=1 in IDLE moves to SWEEP with index 0; ClearReq in SWEEP is ignored.
REQ-019 In SWEEP, each cycle SHALL zero Registers[index] and Pending[index], then increment index; at index 2**A-1 the FSM returns to IDLE and pulses ClearDone for exactly one cycle.
REQ-020 Busy SHALL be 1 exactly while in SWEEP; a sweep takes 2**A cycles.
REQ-021 WrEn and ResvEn SHALL be ignored while Busy=1; reads continue and return current array contents.
REQ-022 Multiple read ports addressing the same register SHALL return identical data.

Reset
REQ-023 Reset=1 SHALL zero all registers, all Pending bits, RdData, RdPending, ClearDone, Busy, and force IDLE, including mid-sweep.
REQ-024 Reset SHALL take priority over ClearReq, WrEn, ResvEn and RdEn in the same cycle.

Configuration
REQ-025 Macro REGFILE_BYPASS_EN defined: a read whose address equals WrAddr with WrEn=1 accepted in the same cycle SHALL return WrData and RdPending=0 (or 1 if ResvEn also targets it).
REQ-026 Macro REGFILE_BYPASS_EN undefined: such a read SHALL return the pre-write value and pre-write Pending.

Structure
REQ-027 The sweep state enum (IDLE, SWEEP) SHALL live in the shared Definitions package.
REQ-028 The scoreboard SHALL be a sub-module reg_scoreboard (2**A pending bits, set/clear/clear-all ports, NR lookup ports).
REQ-029 The top SHALL contain the storage array, read pipeline registers, bypass muxing and sweep FSM only.

Verification
REQ-030 Write 0x5A to r7, next cycle RdEn[0]=1 RdAddr[0]=7 -> RdData[0]=0x5A one cycle later.
REQ-031 Same-cycle WrEn r4=0x33 and read r4 (old 0x11) -> 0x33 with REGFILE_BYPASS_EN, 0x11 without.
REQ-032 ResvEn r9, read r9 -> RdPending=1; write r9=0x01, read -> RdPending=0, RdData=0x01.
REQ-033 Fill all 16 registers, pulse ClearReq -> Busy=1 for 16 cycles, ClearDone pulse on cycle 16, all reads return 0; WrEn during sweep has no effect.
REQ-034 Assert Reset at sweep index 5 -> next cycle Busy=0, ClearDone=0, all registers and Pending 0.
REQ-035 R0_ZERO=1, write r0=0xFF and ResvEn r0 -> read r0 returns 0x00, RdPending=0.
